keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner: drives one column low at a time, synchronises and debounces the active-low row lines, and reports each debounced key press as a one-cycle valid pulse with a binary key code. It is the successor to the fixed 4-row press detector: row and column counts and the timing constants are configurable, columns are scanned, key identity is encoded, multi-key presses are flagged, and release is debounced. It sits between the keypad pins and the control logic that consumes key codes.

---
 rtl/keypad_scanner.sv | 226 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Matrix-keypad scanner. Drives one column low at a time and synchronises the
// active-low row lines with a 2-flop synchroniser. A row pattern seen at the
// end of a column dwell is debounced. When it is accepted, the scanner either
// emits a one-cycle key_valid_o pulse with the binary key code, or emits a
// one-cycle multi_o pulse when more than one row is active. Release is
// debounced before scanning resumes on the next column.
//
// Parameters
//   N_ROWS          number of row inputs (>=1)
//   N_COLS          number of column outputs (>=1)
//   SCAN_CYCLES     cycles each column is held low while scanning (>=3)
//   DEBOUNCE_CYCLES stable cycles required for press and for release (>=1)
//   KW              derived key code width, max(1, $clog2(N_ROWS*N_COLS))
//
// Ports
//   clck_i       system clock
//   rst_i        synchronous active-high reset
//   filas_i      row lines, active-low, asynchronous to clck_i
//   columnas_o   column drive, active-low one-cold
//   key_code_o   code of last accepted key = row*N_COLS + col
//   key_valid_o  one-cycle pulse, key_code_o valid
//   key_held_o   high while an accepted key is held or release is debounced
//   multi_o      one-cycle pulse, more than one row active at acceptance
// -----------------------------------------------------------------------------
module keypad_scanner #(
   parameter int N_ROWS          = 4,
   parameter int N_COLS          = 4,
   parameter int SCAN_CYCLES     = 4,
   parameter int DEBOUNCE_CYCLES = 8,
   localparam int KW = (N_ROWS * N_COLS > 1) ? $clog2(N_ROWS * N_COLS) : 1
) (
   input  logic              clck_i,
   input  logic              rst_i,
   input  logic [N_ROWS-1:0] filas_i,
   output logic [N_COLS-1:0] columnas_o,
   output logic [KW-1:0]     key_code_o,
   output logic              key_valid_o,
   output logic              key_held_o,
   output logic              multi_o
);

   localparam int CW      = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? (SCAN_CYCLES - 1)
                                                            : (DEBOUNCE_CYCLES - 1);
   localparam int CNTW    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   localparam logic [CNTW-1:0] SCAN_LAST = CNTW'(SCAN_CYCLES - 1);
   localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   COL_LAST  = CW'(N_COLS - 1);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_e;

   // True when exactly one row bit is set.
   function automatic logic is_one_hot(input logic [N_ROWS-1:0] p);
      return (p != '0) && ((p & (p - N_ROWS'(1))) == '0);
   endfunction

   // Key code for a one-hot row pattern on column c.
   function automatic logic [KW-1:0] encode_key(input logic [N_ROWS-1:0] p,
                                                input logic [CW-1:0]     c);
      int row;
      row = 0;
      for (int i = 0; i < N_ROWS; i++) begin
         if (p[i]) begin
            row = i;
         end
      end
      return KW'(row * N_COLS + int'(c));
   endfunction

   // Active-low one-cold column drive for column index c.
   function automatic logic [N_COLS-1:0] col_drive(input logic [CW-1:0] c);
      logic [N_COLS-1:0] d;
      for (int i = 0; i < N_COLS; i++) begin
         d[i] = (c != CW'(i));
      end
      return d;
   endfunction

   // Column index after c, wrapping at the last column.
   function automatic logic [CW-1:0] next_col(input logic [CW-1:0] c);
      return (c == COL_LAST) ? CW'(0) : (c + CW'(1));
   endfunction

   state_e              state_q, state_d;
   logic [CW-1:0]       col_q, col_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic [N_ROWS-1:0]   pat_q, pat_d;
   logic [N_ROWS-1:0]   sync1_q, sync2_q;
   logic [N_COLS-1:0]   cols_q, cols_d;
   logic [KW-1:0]       code_q, code_d;
   logic                valid_q, valid_d;
   logic                held_q, held_d;
   logic                multi_q, multi_d;
   logic [N_ROWS-1:0]   rows_pressed;

   // Synchronised rows, 1 = pressed. Synchroniser resets to "no row low".
   assign rows_pressed = ~sync2_q;

   // State, synchroniser and registered outputs.
   always_ff @(posedge clck_i) begin
      if (rst_i) begin
         state_q <= ST_SCAN;
         col_q   <= CW'(0);
         cnt_q   <= CNTW'(0);
         pat_q   <= '0;
         sync1_q <= '1;
         sync2_q <= '1;
         cols_q  <= col_drive(CW'(0));
         code_q  <= KW'(0);
         valid_q <= 1'b0;
         held_q  <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         sync1_q <= filas_i;
         sync2_q <= sync1_q;
         cols_q  <= cols_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         held_q  <= held_d;
         multi_q <= multi_d;
      end
   end

   // Next-state and next-output logic; cnt is the dwell counter in SCAN and
   // the stability counter in DEBOUNCE/RELEASE.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      code_d  = code_q;
      valid_d = 1'b0;
      multi_d = 1'b0;

      case (state_q)
         ST_SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               cnt_d = CNTW'(0);
               if (rows_pressed != '0) begin
                  pat_d   = rows_pressed;
                  state_d = ST_DEBOUNCE;
               end else begin
                  col_d = next_col(col_q);
               end
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end

         ST_DEBOUNCE: begin
            if (rows_pressed == pat_q) begin
               if (cnt_q == DEB_LAST) begin
                  cnt_d   = CNTW'(0);
                  state_d = ST_PRESSED;
                  if (is_one_hot(pat_q)) begin
                     code_d  = encode_key(pat_q, col_q);
                     valid_d = 1'b1;
                  end else begin
                     multi_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end else begin
               // Pattern changed: abandon, re-dwell on the same column.
               cnt_d   = CNTW'(0);
               state_d = ST_SCAN;
            end
         end

         ST_PRESSED: begin
            // Additional keys are ignored here; only a full release matters.
            if (rows_pressed == '0) begin
               cnt_d   = CNTW'(0);
               state_d = ST_RELEASE;
            end else begin
               state_d = ST_PRESSED;
            end
         end

         ST_RELEASE: begin
            if (rows_pressed == '0) begin
               if (cnt_q == DEB_LAST) begin
                  cnt_d   = CNTW'(0);
                  col_d   = next_col(col_q);
                  state_d = ST_SCAN;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end else begin
               // Release bounce: back to held without a new pulse.
               state_d = ST_PRESSED;
            end
         end

         default: begin
            state_d = ST_SCAN;
            col_d   = CW'(0);
            cnt_d   = CNTW'(0);
         end
      endcase

      held_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
      cols_d = col_drive(col_d);
   end

   assign columnas_o  = cols_q;
   assign key_code_o  = code_q;
   assign key_valid_o = valid_q;
   assign key_held_o  = held_q;
   assign multi_o     = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed testbench for keypad_scanner with default parameters (4x4 matrix,
// SCAN_CYCLES = 4, DEBOUNCE_CYCLES = 8). A small keypad model pulls row lines
// low for keys whose column is currently driven low. Outputs are sampled on
// the falling clock edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   logic       clk;
   logic       rst_i;
   logic [3:0] filas_i;
   logic [3:0] columnas_o;
   logic [3:0] key_code_o;
   logic       key_valid_o;
   logic       key_held_o;
   logic       multi_o;

   logic [3:0] press_mask [4];   // per column: rows pressed (1 = pressed)
   logic [3:0] rows_low;

   int n_tests;
   int n_fail;

   keypad_scanner #(
      .N_ROWS(4),
      .N_COLS(4),
      .SCAN_CYCLES(4),
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .clck_i(clk),
      .rst_i(rst_i),
      .filas_i(filas_i),
      .columnas_o(columnas_o),
      .key_code_o(key_code_o),
      .key_valid_o(key_valid_o),
      .key_held_o(key_held_o),
      .multi_o(multi_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: a pressed key connects its row to its column.
   always_comb begin
      rows_low = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         if (columnas_o[c] == 1'b0) begin
            rows_low = rows_low | press_mask[c];
         end
      end
   end
   assign filas_i = ~rows_low;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_keys();
      for (int c = 0; c < 4; c++) press_mask[c] = 4'b0000;
   endtask

   task automatic test_reset();
      logic [3:0] exp_cols;
      clear_keys();
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++; if (columnas_o !== 4'b1110) begin n_fail++; $display("FAIL reset_cols: got %b expected 1110", columnas_o); end
      n_tests++; if (key_code_o !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", key_code_o); end
      n_tests++; if (key_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", key_valid_o); end
      n_tests++; if (key_held_o !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b expected 0", key_held_o); end
      n_tests++; if (multi_o !== 1'b0) begin n_fail++; $display("FAIL reset_multi: got %b expected 0", multi_o); end
      rst_i = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         exp_cols = ~(4'b0001 << ((i / 4) % 4));
         n_tests++; if (columnas_o !== exp_cols) begin n_fail++; $display("FAIL idle_cols[%0d]: got %b expected %b", i, columnas_o, exp_cols); end
         n_tests++; if ({key_valid_o, multi_o, key_held_o} !== 3'b000) begin n_fail++; $display("FAIL idle_outs[%0d]: got %b expected 000", i, {key_valid_o, multi_o, key_held_o}); end
      end
   endtask

   task automatic test_single_press();
      int         waited;
      bit         seen;
      int         bad;
      logic [3:0] got_code;
      logic [3:0] got_cols;
      logic       got_held;
      seen = 1'b0; waited = 0; bad = 0;
      got_code = 4'hx; got_cols = 4'hx; got_held = 1'bx;
      press_mask[1] = 4'b0100;
      while (!seen && waited < 200) begin
         step(); waited++;
         if (multi_o !== 1'b0) bad++;
         if (key_valid_o === 1'b1) begin
            seen = 1'b1; got_code = key_code_o; got_cols = columnas_o; got_held = key_held_o;
         end
      end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL single_timeout: no key_valid_o within %0d cycles", waited); end
      n_tests++; if (got_code !== 4'd9) begin n_fail++; $display("FAIL single_code: got %0d expected 9", got_code); end
      n_tests++; if (got_cols !== 4'b1101) begin n_fail++; $display("FAIL single_cols: got %b expected 1101", got_cols); end
      n_tests++; if (got_held !== 1'b1) begin n_fail++; $display("FAIL single_held_rise: got %b expected 1", got_held); end
      for (int i = 0; i < 30; i++) begin
         step();
         if (key_valid_o !== 1'b0 || multi_o !== 1'b0 || key_held_o !== 1'b1 || columnas_o !== 4'b1101) bad++;
      end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL single_hold: got %0d bad cycles expected 0", bad); end
      press_mask[1] = 4'b0000;
      for (int k = 1; k <= 15; k++) begin
         step();
         if (k == 10) begin
            n_tests++; if (key_held_o !== 1'b1) begin n_fail++; $display("FAIL release_early: held got %b expected 1", key_held_o); end
         end
         if (k == 11) begin
            n_tests++; if (key_held_o !== 1'b0) begin n_fail++; $display("FAIL release_fall: held got %b expected 0", key_held_o); end
            n_tests++; if (columnas_o !== 4'b1011) begin n_fail++; $display("FAIL release_next_col: got %b expected 1011", columnas_o); end
         end
         if (k == 15) begin
            n_tests++; if (columnas_o !== 4'b0111) begin n_fail++; $display("FAIL resume_scan: got %b expected 0111", columnas_o); end
         end
      end
   endtask

   task automatic test_glitch();
      int waited;
      int bad;
      int col3_cnt;
      waited = 0; bad = 0;
      while (columnas_o !== 4'b1011 && waited < 40) begin step(); waited++; end
      while (columnas_o !== 4'b0111 && waited < 50) begin step(); waited++; end
      n_tests++; if (columnas_o !== 4'b0111) begin n_fail++; $display("FAIL glitch_sync: got %b expected 0111", columnas_o); end
      press_mask[3] = 4'b0001;
      col3_cnt = 1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (k == 5) press_mask[3] = 4'b0000;
         if (k <= 15 && columnas_o === 4'b0111) col3_cnt++;
         if (key_valid_o !== 1'b0 || multi_o !== 1'b0 || key_held_o !== 1'b0) bad++;
      end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL glitch_pulse: got %0d bad cycles expected 0", bad); end
      n_tests++; if (col3_cnt !== 12) begin n_fail++; $display("FAIL glitch_dwell: col3 held %0d cycles expected 12", col3_cnt); end
      n_tests++; if (key_code_o !== 4'd9) begin n_fail++; $display("FAIL glitch_code: got %0d expected 9", key_code_o); end
   endtask

   task automatic test_multi();
      int         waited;
      int         n_valid;
      int         n_multi;
      int         bad;
      logic       got_held;
      logic [3:0] got_cols;
      waited = 0; n_valid = 0; n_multi = 0; bad = 0;
      got_held = 1'bx; got_cols = 4'hx;
      press_mask[0] = 4'b1001;
      while (n_multi == 0 && waited < 100) begin
         step(); waited++;
         if (key_valid_o === 1'b1) n_valid++;
         if (multi_o === 1'b1) begin n_multi++; got_held = key_held_o; got_cols = columnas_o; end
      end
      n_tests++; if (n_multi !== 1) begin n_fail++; $display("FAIL multi_pulse: got %0d pulses expected 1", n_multi); end
      n_tests++; if (got_held !== 1'b1) begin n_fail++; $display("FAIL multi_held: got %b expected 1", got_held); end
      n_tests++; if (got_cols !== 4'b1110) begin n_fail++; $display("FAIL multi_cols: got %b expected 1110", got_cols); end
      n_tests++; if (key_code_o !== 4'd9) begin n_fail++; $display("FAIL multi_code: got %0d expected 9", key_code_o); end
      for (int i = 0; i < 20; i++) begin
         step();
         if (key_valid_o === 1'b1) n_valid++;
         if (multi_o === 1'b1) n_multi++;
         if (key_held_o !== 1'b1) bad++;
      end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL multi_hold: got %0d cycles with held low expected 0", bad); end
      press_mask[0] = 4'b0000;
      waited = 0;
      while (key_held_o !== 1'b0 && waited < 30) begin
         step(); waited++;
         if (key_valid_o === 1'b1) n_valid++;
         if (multi_o === 1'b1) n_multi++;
      end
      n_tests++; if (key_held_o !== 1'b0) begin n_fail++; $display("FAIL multi_release: held got %b expected 0", key_held_o); end
      n_tests++; if (n_valid !== 0) begin n_fail++; $display("FAIL multi_no_valid: got %0d pulses expected 0", n_valid); end
      n_tests++; if (n_multi !== 1) begin n_fail++; $display("FAIL multi_single: got %0d pulses expected 1", n_multi); end
   endtask

   task automatic test_release_bounce();
      int   n_valid;
      int   n_multi;
      int   n_falls;
      logic prev_held;
      n_valid = 0; n_multi = 0; n_falls = 0;
      prev_held = key_held_o;
      press_mask[1] = 4'b0100;
      for (int i = 0; i < 100 && n_valid == 0; i++) begin
         step();
         if (key_valid_o === 1'b1) n_valid++;
         if (multi_o === 1'b1) n_multi++;
         if (prev_held === 1'b1 && key_held_o === 1'b0) n_falls++;
         prev_held = key_held_o;
      end
      for (int t = 0; t < 10; t++) begin
         press_mask[1] = (t % 2 == 0) ? 4'b0000 : 4'b0100;
         repeat (3) begin
            step();
            if (key_valid_o === 1'b1) n_valid++;
            if (multi_o === 1'b1) n_multi++;
            if (prev_held === 1'b1 && key_held_o === 1'b0) n_falls++;
            prev_held = key_held_o;
         end
      end
      press_mask[1] = 4'b0100;
      for (int i = 0; i < 40; i++) begin
         if (i == 20) press_mask[1] = 4'b0000;
         step();
         if (key_valid_o === 1'b1) n_valid++;
         if (multi_o === 1'b1) n_multi++;
         if (prev_held === 1'b1 && key_held_o === 1'b0) n_falls++;
         prev_held = key_held_o;
      end
      n_tests++; if (n_valid !== 1) begin n_fail++; $display("FAIL bounce_valid: got %0d pulses expected 1", n_valid); end
      n_tests++; if (n_multi !== 0) begin n_fail++; $display("FAIL bounce_multi: got %0d pulses expected 0", n_multi); end
      n_tests++; if (n_falls !== 1) begin n_fail++; $display("FAIL bounce_falls: got %0d held falls expected 1", n_falls); end
      n_tests++; if (key_code_o !== 4'd9) begin n_fail++; $display("FAIL bounce_code: got %0d expected 9", key_code_o); end
   endtask

   task automatic test_reset_mid_press();
      int         n_valid;
      int         n_multi;
      logic [3:0] got_code;
      n_valid = 0; n_multi = 0; got_code = 4'hx;
      press_mask[1] = 4'b0100;
      for (int i = 0; i < 100 && n_valid == 0; i++) begin
         step();
         if (key_valid_o === 1'b1) n_valid++;
      end
      n_tests++; if (n_valid !== 1) begin n_fail++; $display("FAIL midrst_accept: got %0d pulses expected 1", n_valid); end
      repeat (5) step();
      rst_i = 1'b1;
      step();
      n_tests++; if (columnas_o !== 4'b1110) begin n_fail++; $display("FAIL midrst_cols: got %b expected 1110", columnas_o); end
      n_tests++; if (key_code_o !== 4'd0) begin n_fail++; $display("FAIL midrst_code: got %0d expected 0", key_code_o); end
      n_tests++; if (key_held_o !== 1'b0) begin n_fail++; $display("FAIL midrst_held: got %b expected 0", key_held_o); end
      n_tests++; if ({key_valid_o, multi_o} !== 2'b00) begin n_fail++; $display("FAIL midrst_pulses: got %b expected 00", {key_valid_o, multi_o}); end
      step();
      n_tests++; if ({key_valid_o, multi_o, key_held_o} !== 3'b000) begin n_fail++; $display("FAIL midrst_hold: got %b expected 000", {key_valid_o, multi_o, key_held_o}); end
      rst_i = 1'b0;
      n_valid = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (key_valid_o === 1'b1) begin n_valid++; got_code = key_code_o; end
         if (multi_o === 1'b1) n_multi++;
      end
      n_tests++; if (n_valid !== 1) begin n_fail++; $display("FAIL midrst_reaccept: got %0d pulses expected 1", n_valid); end
      n_tests++; if (got_code !== 4'd9) begin n_fail++; $display("FAIL midrst_recode: got %0d expected 9", got_code); end
      n_tests++; if (n_multi !== 0) begin n_fail++; $display("FAIL midrst_multi: got %0d pulses expected 0", n_multi); end
      n_tests++; if (columnas_o !== 4'b1101 || key_held_o !== 1'b1) begin n_fail++; $display("FAIL midrst_held_after: cols %b held %b expected 1101 1", columnas_o, key_held_o); end
      press_mask[1] = 4'b0000;
      repeat (20) step();
      n_tests++; if (key_held_o !== 1'b0) begin n_fail++; $display("FAIL midrst_release: held got %b expected 0", key_held_o); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_i   = 1'b1;
      clear_keys();
      test_reset();
      test_single_press();
      test_glitch();
      test_multi();
      test_release_bounce();
      test_reset_mid_press();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within 200000 time units");
      $fatal(1);
   end

endmodule
